// File: rtl/snake_body_buffer.sv
// Snake body store for the 160x120 VGA snake game.
// Keeps the segment coordinates in a circular buffer, with the head at head_ptr.
// A step runs as a short sequence: wall check, one-segment-per-cycle body scan,
// then commit or reject. Segments are read through a registered indexed port.
module snake_body_buffer #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int IDX_W    = 5,
    parameter int STEP     = 10,
    parameter int X0       = 80,
    parameter int Y0       = 60,
    parameter int XMAX     = 160,
    parameter int YMAX     = 120
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             init,
    input  logic             step,
    input  logic [1:0]       dir,
    input  logic             grow,
    output logic             busy,
    output logic             done,
    output logic             hit_wall,
    output logic             hit_self,
    output logic [IDX_W-1:0] length,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_x,
    output logic [6:0]       rd_y,
    output logic [7:0]       tail_x,
    output logic [6:0]       tail_y,
    output logic             tail_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WALL   = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Array address width; slot pointers are always < MAX_LEN so the low bits suffice.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [IDX_W-1:0] LEN_MAX   = IDX_W'(MAX_LEN);
    localparam logic [IDX_W-1:0] LEN_INIT  = IDX_W'(INIT_LEN);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_LEN - 1);
    localparam logic [IDX_W:0]   LEN_MAX_X = (IDX_W+1)'(MAX_LEN);
    localparam logic [8:0]       STEP9     = 9'(STEP);
    localparam logic [8:0]       X_LIM     = 9'(XMAX - STEP);
    localparam logic [8:0]       Y_LIM     = 9'(YMAX - STEP);

    // Each entry packs {x[7:0], y[6:0]}.
    logic [14:0]      seg_mem [MAX_LEN];

    logic [1:0]       state;
    logic [IDX_W-1:0] head_ptr;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] scan_n;
    logic [1:0]       eff_dir;
    logic [1:0]       last_dir;
    logic             grow_q;
    logic             match_q;
    logic [7:0]       cand_x;
    logic [6:0]       cand_y;

    logic [7:0]       head_x;
    logic [6:0]       head_y;
    logic [8:0]       next_x;
    logic [8:0]       next_y;
    logic             wall_fail;
    logic             can_grow;
    logic [IDX_W-1:0] new_head;
    logic [IDX_W-1:0] scan_slot;
    logic [IDX_W-1:0] tail_slot;
    logic [IDX_W-1:0] rd_slot;

    // Physical slot of logical segment 'off', wrapping explicitly at MAX_LEN.
    function automatic logic [IDX_W-1:0] seg_addr(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= LEN_MAX_X) sum = sum - LEN_MAX_X;
        return sum[IDX_W-1:0];
    endfunction

    // Starting layout: a vertical column below the head, unused slots zero.
    function automatic logic [14:0] init_seg(input int i);
        if (i < INIT_LEN) return {8'(X0), 7'(Y0 + i * STEP)};
        return 15'd0;
    endfunction

    assign busy      = (state != S_IDLE);
    assign can_grow  = grow_q && (length < LEN_MAX);
    assign new_head  = (head_ptr == '0) ? LAST_SLOT : head_ptr - 1'b1;
    assign scan_slot = seg_addr(head_ptr, scan_idx);
    assign tail_slot = seg_addr(head_ptr, length - 1'b1);
    assign rd_slot   = seg_addr(head_ptr, rd_idx);
    assign head_x    = seg_mem[head_ptr[AW-1:0]][14:7];
    assign head_y    = seg_mem[head_ptr[AW-1:0]][6:0];

    // Candidate head and wall test in 9-bit arithmetic so underflow shows as a compare.
    always_comb begin
        next_x    = {1'b0, head_x};
        next_y    = {2'b0, head_y};
        wall_fail = 1'b0;
        case (eff_dir)
            DIR_RIGHT: begin
                next_x    = {1'b0, head_x} + STEP9;
                wall_fail = (next_x > X_LIM);
            end
            DIR_LEFT: begin
                wall_fail = ({1'b0, head_x} < STEP9);
                next_x    = {1'b0, head_x} - STEP9;
            end
            DIR_DOWN: begin
                next_y    = {2'b0, head_y} + STEP9;
                wall_fail = (next_y > Y_LIM);
            end
            default: begin
                wall_fail = ({2'b0, head_y} < STEP9);
                next_y    = {2'b0, head_y} - STEP9;
            end
        endcase
    end

    // Step sequencer and body storage: accept, wall check, body scan, commit.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < MAX_LEN; i++) seg_mem[i] <= init_seg(i);
            state      <= S_IDLE;
            head_ptr   <= '0;
            length     <= LEN_INIT;
            last_dir   <= DIR_UP;
            eff_dir    <= DIR_UP;
            grow_q     <= 1'b0;
            match_q    <= 1'b0;
            scan_idx   <= '0;
            scan_n     <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            done       <= 1'b0;
            hit_wall   <= 1'b0;
            hit_self   <= 1'b0;
            tail_x     <= '0;
            tail_y     <= '0;
            tail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (init) begin
                for (int i = 0; i < MAX_LEN; i++) seg_mem[i] <= init_seg(i);
                state      <= S_IDLE;
                head_ptr   <= '0;
                length     <= LEN_INIT;
                last_dir   <= DIR_UP;
                hit_wall   <= 1'b0;
                hit_self   <= 1'b0;
                tail_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (step) begin
                            // A request to reverse onto the neck keeps the old heading.
                            eff_dir  <= (dir == ~last_dir) ? last_dir : dir;
                            grow_q   <= grow;
                            hit_wall <= 1'b0;
                            hit_self <= 1'b0;
                            state    <= S_WALL;
                        end
                    end
                    S_WALL: begin
                        if (wall_fail) begin
                            hit_wall <= 1'b1;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            cand_x   <= next_x[7:0];
                            cand_y   <= next_y[6:0];
                            scan_idx <= '0;
                            // The tail cell is vacated by a plain move, so it is not scanned.
                            scan_n   <= can_grow ? length : length - 1'b1;
                            match_q  <= 1'b0;
                            state    <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (seg_mem[scan_slot[AW-1:0]] == {cand_x, cand_y}) match_q <= 1'b1;
                        if (scan_idx == scan_n - 1'b1) state <= S_COMMIT;
                        else                           scan_idx <= scan_idx + 1'b1;
                    end
                    default: begin
                        if (match_q) begin
                            hit_self <= 1'b1;
                        end else begin
                            head_ptr                   <= new_head;
                            seg_mem[new_head[AW-1:0]]  <= {cand_x, cand_y};
                            last_dir                   <= eff_dir;
                            if (can_grow) begin
                                length     <= length + 1'b1;
                                tail_valid <= 1'b0;
                            end else begin
                                // Read before the new head may overwrite this slot (full buffer).
                                {tail_x, tail_y} <= seg_mem[tail_slot[AW-1:0]];
                                tail_valid       <= 1'b1;
                            end
                        end
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Registered read port; indices beyond the current length read as zero.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_x <= '0;
            rd_y <= '0;
        end else if (rd_idx < length) begin
            {rd_x, rd_y} <= seg_mem[rd_slot[AW-1:0]];
        end else begin
            rd_x <= '0;
            rd_y <= '0;
        end
    end

endmodule

// File: doc/snake_body_buffer.md
# snake_body_buffer

Parametrised snake-body store for the 160x120 VGA snake game. It holds up to MAX_LEN segment coordinates in a circular buffer and advances the head one cell per step command. It optionally grows instead of dropping the tail, and checks wall and self-collision before committing. The drawing FSM reads segments through an indexed read port and erases the vacated tail cell reported after each step.

## Interface
- MAX_LEN, 16: buffer depth, the maximum segment count (need not be a power of 2).
- INIT_LEN, 4: length after reset or init, with 2 <= INIT_LEN <= MAX_LEN.
- IDX_W, 5: width of index and length fields; 2^IDX_W > MAX_LEN.
- STEP, 10: cell size in pixels, the per-step displacement.
- X0, 80: initial head x.
- Y0, 60: initial head y.
- XMAX, 160: screen width.
- YMAX, 120: screen height.

Ports (direction, width, meaning):
- Clock, in, 1: system clock (CLOCK_50).
- Resetn, in, 1: asynchronous, active-low reset.
- init, in, 1: synchronous reload of the initial snake; aborts any operation in progress.
- step, in, 1: single-cycle request to advance one cell.
- dir, in, 2: 00 = right, 01 = down, 10 = up, 11 = left.
- grow, in, 1: sampled with step; keep the tail (length+1).
- busy, out, 1: high while a step is in progress.
- done, out, 1: one-cycle pulse when a step finishes, moved or rejected.
- hit_wall, out, 1: last step was rejected because the next head would leave the screen.
- hit_self, out, 1: last step was rejected because the next head overlaps the body.
- length, out, IDX_W: current segment count.
- rd_idx, in, IDX_W: segment index, with 0 = head.
- rd_x, out, 8: x of segment rd_idx, registered.
- rd_y, out, 7: y of segment rd_idx, registered.
- tail_x, out, 8: x of the cell vacated by the last committed step.
- tail_y, out, 7: y of the cell vacated by the last committed step.
- tail_valid, out, 1: tail_x/tail_y hold a cell to erase.

## Operation
**Storage**
- MAX_LEN x 15-bit entries plus head_ptr. Segment i lives at (head_ptr + i) mod MAX_LEN, with explicit wrap.
- Reset and init values: head_ptr = 0, length = INIT_LEN, segment i = (X0, Y0 + i*STEP) for i < INIT_LEN, last_dir = up.
- Output reset values: busy, done, hit_wall, hit_self, tail_valid, rd_x, rd_y, tail_x and tail_y are all 0.

**States**
- IDLE: accept step when busy = 0. Latch eff_dir = dir, unless dir is the exact reverse of last_dir, in which case eff_dir = last_dir. Latch grow. Clear hit_wall and hit_self. Go to WALL.
- WALL: compute the candidate head in 9-bit arithmetic.
  - right fails if x + STEP > XMAX - STEP; left fails if x < STEP.
  - down fails if y + STEP > YMAX - STEP; up fails if y < STEP.
  - On failure, set hit_wall and go to IDLE with done pulsed.
  - Otherwise go to SCAN with scan index 0.
- SCAN: compare the candidate against one segment per cycle, for N cycles.
  - N = length when growing and length < MAX_LEN.
  - Otherwise N = length - 1, excluding the tail. Moving into the current tail cell without growing is legal.
  - A match sets a sticky flag. After N cycles, go to COMMIT.
- COMMIT:
  - If the flag is set: hit_self = 1, buffer unchanged.
  - Else: head_ptr = (head_ptr - 1) mod MAX_LEN, write the candidate at the new head_ptr, last_dir = eff_dir.
  - Grow with length < MAX_LEN: length + 1, tail_valid = 0.
  - Otherwise: tail_x/tail_y = old tail, tail_valid = 1. Growth saturates at MAX_LEN and then behaves as a plain move.
  - Go to IDLE with done pulsed.

**Input priority and read port**
- step while busy = 1 is ignored.
- init has priority over step in the same cycle. init while busy aborts and returns to IDLE next cycle with no done pulse. init clears hit flags and tail_valid.
- Read port: rd_x/rd_y are registered from rd_idx. When rd_idx >= length, rd_x/rd_y = 0.

## Timing
- step sampled at edge T: WALL during cycle T+1.
- Wall reject: done and hit_wall visible in cycle T+2.
- Otherwise SCAN occupies cycles T+2 .. T+1+N and COMMIT occupies cycle T+2+N. done, the updated length/tail/hit flags and busy = 0 are visible in cycle T+3+N.
- busy is high from cycle T+1 until done.
- Read latency is 1 cycle. rd_x/rd_y reflect a commit from the cycle after done.
- Reset assertion mid-operation immediately restores reset values.
- hit_wall, hit_self and tail_* hold until the next accepted step or init.

## Test plan
- Reset, then read idx 0..3 → (80,60), (80,70), (80,80), (80,90); idx 4 → (0,0); length = 4; busy = 0.
- step dir=right grow=0 → done at T+6; head (90,60); idx1 (80,60); tail (80,90) with tail_valid = 1; length = 4.
- step dir=up grow=1 from reset → done at T+7; head (80,50); length = 5; tail_valid = 0. Repeat grow to MAX_LEN=16, then one more grow step → length stays 16 and tail_valid = 1.
- After reset (last_dir = up), step dir=down → reversal ignored; head (80,50).
- Seven steps right from reset → head (150,60). An eighth step right → done at T+2, hit_wall = 1, head still (150,60).
- After grow-up, then right, then down (head (90,60)), step left → candidate (80,60) equals idx3: hit_self = 1, buffer and length = 5 unchanged. Separately, an init asserted during SCAN → reset layout restored and no done pulse.
